// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: fixed-latency mult/div with flush, HI/LO and mthi/mtlo.
// Define MD_MADD_EN to enable the madd/msub (op 6/7) accumulate operations.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_op_valid,
  input  logic [2:0]       i_op,
  input  logic [WIDTH-1:0] i_num1,
  input  logic [WIDTH-1:0] i_num2,
  input  logic             i_flush,
  output logic             o_start,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  localparam logic [2:0] OpMult  = 3'd0;
  localparam logic [2:0] OpMultu = 3'd1;
  localparam logic [2:0] OpDiv   = 3'd2;
  localparam logic [2:0] OpDivu  = 3'd3;
  localparam logic [2:0] OpMthi  = 3'd4;
  localparam logic [2:0] OpMtlo  = 3'd5;
`ifdef MD_MADD_EN
  localparam logic [2:0] OpMadd  = 3'd6;
  localparam logic [2:0] OpMsub  = 3'd7;
`endif

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             r_state;
  state_e             w_state_next;
  logic [CntW-1:0]    r_cnt;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_hi_p;
  logic [WIDTH-1:0]   r_lo_p;

  logic               w_is_md;
  logic               w_is_div;
  logic               w_idle_wr;
  logic               w_accept;
  logic               w_commit;
  logic [2*WIDTH-1:0] w_ext1;
  logic [2*WIDTH-1:0] w_ext2;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [2*WIDTH-1:0] w_prod_u;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [WIDTH-1:0]   w_dvd;
  logic [WIDTH-1:0]   w_dvs;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_div0;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_hi_res;
  logic [WIDTH-1:0]   w_lo_res;

  always_comb begin
    w_is_md = 1'b0;
    case (i_op)
      OpMult, OpMultu, OpDiv, OpDivu: w_is_md = 1'b1;
`ifdef MD_MADD_EN
      OpMadd, OpMsub:                 w_is_md = 1'b1;
`endif
      default:                        w_is_md = 1'b0;
    endcase
  end

  assign w_is_div  = (i_op == OpDiv) || (i_op == OpDivu);
  assign w_idle_wr = i_op_valid && (r_state == StIdle) && !i_flush;
  assign w_accept  = w_idle_wr && w_is_md;
  assign w_commit  = (r_state == StRun) && (r_cnt == CntW'(1)) && !i_flush;

  // Sign-extended operands give the signed product modulo 2^(2*WIDTH).
  assign w_ext1   = {{WIDTH{i_num1[WIDTH-1]}}, i_num1};
  assign w_ext2   = {{WIDTH{i_num2[WIDTH-1]}}, i_num2};
  assign w_prod_s = w_ext1 * w_ext2;
  assign w_prod_u = {{WIDTH{1'b0}}, i_num1} * {{WIDTH{1'b0}}, i_num2};

  // One unsigned divider serves both: div feeds it magnitudes and fixes signs afterwards.
  assign w_neg1 = i_num1[WIDTH-1];
  assign w_neg2 = i_num2[WIDTH-1];
  assign w_abs1 = w_neg1 ? -i_num1 : i_num1;
  assign w_abs2 = w_neg2 ? -i_num2 : i_num2;
  assign w_div0 = (i_num2 == '0);
  assign w_ovf  = (i_num1 == {1'b1, {(WIDTH-1){1'b0}}}) && (i_num2 == '1);
  assign w_dvd  = (i_op == OpDiv) ? w_abs1 : i_num1;
  assign w_dvs  = w_div0 ? WIDTH'(1) : ((i_op == OpDiv) ? w_abs2 : i_num2);
  assign w_quo  = w_dvd / w_dvs;
  assign w_rem  = w_dvd % w_dvs;

  always_comb begin
    w_hi_res = r_hi;
    w_lo_res = r_lo;
    case (i_op)
      OpMult:  {w_hi_res, w_lo_res} = w_prod_s;
      OpMultu: {w_hi_res, w_lo_res} = w_prod_u;
      OpDiv: begin
        if (w_div0) begin
          w_hi_res = i_num1;
          w_lo_res = '1;
        end else if (w_ovf) begin
          w_hi_res = '0;
          w_lo_res = i_num1;
        end else begin
          w_hi_res = w_neg1 ? -w_rem : w_rem;
          w_lo_res = (w_neg1 ^ w_neg2) ? -w_quo : w_quo;
        end
      end
      OpDivu: begin
        if (w_div0) begin
          w_hi_res = i_num1;
          w_lo_res = '1;
        end else begin
          w_hi_res = w_rem;
          w_lo_res = w_quo;
        end
      end
`ifdef MD_MADD_EN
      OpMadd:  {w_hi_res, w_lo_res} = {r_hi, r_lo} + w_prod_s;
      OpMsub:  {w_hi_res, w_lo_res} = {r_hi, r_lo} - w_prod_s;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  if (w_accept) w_state_next = StRun;
      StRun:   if (i_flush || (r_cnt == CntW'(1))) w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    o_start = w_accept;
    o_busy  = (r_state == StRun);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt  <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_hi_p <= '0;
      r_lo_p <= '0;
    end else begin
      if (i_flush) begin
        r_cnt  <= '0;
        r_hi_p <= '0;
        r_lo_p <= '0;
      end else if (w_accept) begin
        r_cnt  <= w_is_div ? CntW'(DIV_CYCLES) : CntW'(MULT_CYCLES);
        r_hi_p <= w_hi_res;
        r_lo_p <= w_lo_res;
      end else if (r_state == StRun) begin
        r_cnt <= r_cnt - CntW'(1);
      end

      if (w_commit) begin
        r_hi <= r_hi_p;
        r_lo <= r_lo_p;
      end else if (w_idle_wr && (i_op == OpMthi)) begin
        r_hi <= i_num1;
      end else if (w_idle_wr && (i_op == OpMtlo)) begin
        r_lo <= i_num1;
      end
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: behavioural HI/LO model checked every cycle plus directed literals.
module tb_md_unit;

`ifdef MD_MADD_EN
  localparam bit MaddEn = 1'b1;
`else
  localparam bit MaddEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] num1 = '0;
  logic [31:0] num2 = '0;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  md_unit #(
    .WIDTH(32),
    .MULT_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .i_clk(clk),
    .i_reset(reset),
    .i_op_valid(op_valid),
    .i_op(op),
    .i_num1(num1),
    .i_num2(num2),
    .i_flush(flush),
    .o_start(start),
    .o_busy(busy),
    .o_hi(hi),
    .o_lo(lo)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: architectural HI/LO, a pending result, and remaining busy cycles.
  bit          m_on = 1'b0;
  int          m_rem = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] m_hi_p = '0;
  logic [31:0] m_lo_p = '0;

  function automatic bit md_class(input logic [2:0] o);
    return (o <= 3'd3) || (MaddEn && (o == 3'd6 || o == 3'd7));
  endfunction

  task automatic model_accept(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint          p;
    longint unsigned pu;
    logic [63:0]     acc;
    int              sa;
    int              sb;
    p  = longint'($signed(a)) * longint'($signed(b));
    pu = {32'b0, a} * {32'b0, b};
    sa = a;
    sb = b;
    m_rem = 5;
    case (o)
      3'd0: begin m_hi_p = p[63:32]; m_lo_p = p[31:0]; end
      3'd1: begin m_hi_p = pu[63:32]; m_lo_p = pu[31:0]; end
      3'd2: begin
        m_rem = 10;
        if (b == 0) begin m_lo_p = 32'hFFFF_FFFF; m_hi_p = a; end
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin m_lo_p = a; m_hi_p = 0; end
        else begin m_lo_p = sa / sb; m_hi_p = sa % sb; end
      end
      3'd3: begin
        m_rem = 10;
        if (b == 0) begin m_lo_p = 32'hFFFF_FFFF; m_hi_p = a; end
        else begin m_lo_p = a / b; m_hi_p = a % b; end
      end
      3'd6: begin acc = {m_hi, m_lo} + p; m_hi_p = acc[63:32]; m_lo_p = acc[31:0]; end
      default: begin acc = {m_hi, m_lo} - p; m_hi_p = acc[63:32]; m_lo_p = acc[31:0]; end
    endcase
  endtask

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1'b1; m_rem = 0; m_hi = '0; m_lo = '0;
    end else if (flush) begin
      m_rem = 0;
    end else if (m_rem > 0) begin
      if (m_rem == 1) begin m_hi = m_hi_p; m_lo = m_lo_p; end
      m_rem--;
    end else if (op_valid) begin
      if (op == 3'd4) m_hi = num1;
      else if (op == 3'd5) m_lo = num1;
      else if (md_class(op)) model_accept(op, num1, num2);
    end
  end

  always @(negedge clk) begin
    if (m_on && !reset) begin
      chk("model_busy", {31'b0, busy}, {31'b0, m_rem > 0});
      chk("model_start", {31'b0, start},
          {31'b0, op_valid && !flush && m_rem == 0 && md_class(op)});
      chk("model_hi", hi, m_hi);
      chk("model_lo", lo, m_lo);
    end
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    op_valid = 1'b0; op = 3'd0; num1 = '0; num2 = '0;
  endtask

  task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    op_valid = 1'b1; op = o; num1 = a; num2 = b;
    #1;
  endtask

  // Issue in cycle T, return in cycle T+n+1.
  task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int n);
    drive(o, a, b);
    step;
    idle;
    repeat (n) step;
  endtask

  initial begin
    reset = 1'b1;
    step;
    step;
    reset = 1'b0;
    chk("reset_hi", hi, 32'h0);
    chk("reset_lo", lo, 32'h0);
    chk("reset_busy", {31'b0, busy}, 32'h0);

    drive(3'd0, 32'hFFFF_FFFE, 32'd3);
    chk("mult_start", {31'b0, start}, 32'h1);
    step;
    idle;
    chk("mult_busy_t1", {31'b0, busy}, 32'h1);
    repeat (4) step;
    chk("mult_busy_t5", {31'b0, busy}, 32'h1);
    step;
    chk("mult_busy_t6", {31'b0, busy}, 32'h0);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    run(3'd2, 32'hFFFF_FFF9, 32'd2, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);
    run(3'd3, 32'hFFFF_FFF9, 32'd2, 10);
    chk("divu_lo", lo, 32'h7FFF_FFFC);
    chk("divu_hi", hi, 32'h1);
    run(3'd3, 32'd5, 32'd0, 10);
    chk("div0_lo", lo, 32'hFFFF_FFFF);
    chk("div0_hi", hi, 32'd5);
    run(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    drive(3'd4, 32'h1234, 32'd0);
    chk("mthi_start", {31'b0, start}, 32'h0);
    step;
    idle;
    chk("mthi_hi", hi, 32'h1234);
    drive(3'd1, 32'hFFFF, 32'hFFFF);
    step;
    idle;
    step;
    step;
    flush = 1'b1;
    step;
    flush = 1'b0;
    chk("flush_busy", {31'b0, busy}, 32'h0);
    repeat (8) step;
    chk("flush_hi", hi, 32'h1234);
    chk("flush_lo", lo, 32'h8000_0000);
    drive(3'd0, 32'd5, 32'd5);
    flush = 1'b1;
    #1;
    chk("flush_same_start", {31'b0, start}, 32'h0);
    step;
    idle;
    flush = 1'b0;
    chk("flush_same_busy", {31'b0, busy}, 32'h0);

    drive(3'd1, 32'hFFFF, 32'hFFFF);
    step;
    idle;
    step;
    drive(3'd5, 32'hAA, 32'd0);
    step;
    idle;
    step;
    step;
    step;
    chk("blk_busy", {31'b0, busy}, 32'h0);
    chk("blk_lo", lo, 32'hFFFE_0001);
    chk("blk_hi", hi, 32'h0);
    drive(3'd5, 32'hAA, 32'd0);
    step;
    idle;
    chk("mtlo_lo", lo, 32'hAA);

    drive(3'd4, 32'd0, 32'd0);
    step;
    drive(3'd5, 32'hFFFF_FFFF, 32'd0);
    step;
    idle;
    drive(3'd6, 32'd1, 32'd1);
    chk("madd_start", {31'b0, start}, {31'b0, MaddEn});
    step;
    idle;
    repeat (5) step;
    chk("madd_busy", {31'b0, busy}, 32'h0);
`ifdef MD_MADD_EN
    chk("madd_hi", hi, 32'h1);
    chk("madd_lo", lo, 32'h0);
    run(3'd7, 32'd1, 32'd1, 5);
    chk("msub_hi", hi, 32'h0);
    chk("msub_lo", lo, 32'hFFFF_FFFF);
`else
    chk("madd_hi", hi, 32'h0);
    chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

    drive(3'd1, 32'd3, 32'd3);
    step;
    drive(3'd0, 32'd7, 32'd7);
    step;
    idle;
    repeat (4) step;
    chk("ignored_lo", lo, 32'd9);
    chk("ignored_hi", hi, 32'd0);

    drive(3'd0, 32'd3, 32'd3);
    step;
    idle;
    step;
    reset = 1'b1;
    step;
    reset = 1'b0;
    chk("rst_mid_busy", {31'b0, busy}, 32'h0);
    chk("rst_mid_hi", hi, 32'h0);
    chk("rst_mid_lo", lo, 32'h0);
    step;
    step;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
